// File: rtl/tex_rsp_commit.sv
// tex_rsp_commit: receiving end of the texture response channel.
// Buffers full-warp responses in a small FIFO and serializes each one onto a
// NUM_LANES-wide commit port, skipping lane groups that have no active threads.
// Optional macro TEX_RSP_COMMIT_PERF_EN adds push and stall performance counters.

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module tex_rsp_commit #(
    parameter int NUM_THREADS = `NUM_THREADS,
    parameter int NUM_LANES   = 2,
    parameter int DEPTH       = 2,
    localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
    localparam int PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      rsp_valid_in,
    input  logic [`UUID_BITS-1:0]     rsp_uuid_in,
    input  logic [`NW_BITS-1:0]       rsp_wid_in,
    input  logic [NUM_THREADS-1:0]    rsp_tmask_in,
    input  logic [31:0]               rsp_PC_in,
    input  logic [`NR_BITS-1:0]       rsp_rd_in,
    input  logic                      rsp_wb_in,
    input  logic [NUM_THREADS*32-1:0] rsp_data_in,
    output logic                      rsp_ready_out,

    output logic                      cmt_valid,
    output logic [`UUID_BITS-1:0]     cmt_uuid,
    output logic [`NW_BITS-1:0]       cmt_wid,
    output logic [31:0]               cmt_PC,
    output logic [`NR_BITS-1:0]       cmt_rd,
    output logic                      cmt_wb,
    output logic [NUM_LANES-1:0]      cmt_tmask,
    output logic [NUM_LANES*32-1:0]   cmt_data,
    output logic [PID_W-1:0]          cmt_pid,
    output logic                      cmt_sop,
    output logic                      cmt_eop,
`ifdef TEX_RSP_COMMIT_PERF_EN
    output logic [31:0]               perf_rsp_count,
    output logic [31:0]               perf_stall_count,
`endif
    input  logic                      cmt_ready
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = `UUID_BITS + `NW_BITS + NUM_THREADS + 32 + `NR_BITS + 1
                           + NUM_THREADS * 32;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic             sop_q, sop_d;

    logic             push, fire, pop;

    logic [`UUID_BITS-1:0]     h_uuid;
    logic [`NW_BITS-1:0]       h_wid;
    logic [NUM_THREADS-1:0]    h_tmask;
    logic [31:0]               h_pc;
    logic [`NR_BITS-1:0]       h_rd;
    logic                      h_wb;
    logic [NUM_THREADS*32-1:0] h_data;

    logic [NUM_PKTS-1:0] grp_nz;
    logic [PID_W-1:0]    first_pid;
    logic [PID_W-1:0]    cur_pid;
    logic [PID_W-1:0]    nxt_pid;
    logic                has_next;

    assign rsp_ready_out = (count_q != (AW+1)'(DEPTH));
    assign cmt_valid     = (count_q != '0);

    assign push = rsp_valid_in & rsp_ready_out;
    assign fire = cmt_valid & cmt_ready;
    assign pop  = fire & cmt_eop;

    assign {h_uuid, h_wid, h_tmask, h_pc, h_rd, h_wb, h_data} = mem_q[rd_ptr_q];

    // Lane-group activity and lowest/next active group of the head entry
    always_comb begin
        grp_nz    = '0;
        first_pid = '0;
        nxt_pid   = '0;
        has_next  = 1'b0;
        for (int g = 0; g < NUM_PKTS; g++) begin
            grp_nz[g] = |h_tmask[g*NUM_LANES +: NUM_LANES];
        end
        for (int g = NUM_PKTS - 1; g >= 0; g--) begin
            if (grp_nz[g]) first_pid = PID_W'(g);
        end
        // An all-zero mask leaves first_pid at 0, giving the single empty beat
        cur_pid = sop_q ? first_pid : pid_q;
        for (int g = NUM_PKTS - 1; g >= 0; g--) begin
            if (grp_nz[g] && (g > int'(cur_pid))) begin
                nxt_pid  = PID_W'(g);
                has_next = 1'b1;
            end
        end
    end

    // Commit beat outputs taken from the head entry and current lane group
    always_comb begin
        cmt_uuid  = h_uuid;
        cmt_wid   = h_wid;
        cmt_PC    = h_pc;
        cmt_rd    = h_rd;
        cmt_wb    = h_wb;
        cmt_pid   = cur_pid;
        cmt_sop   = sop_q;
        cmt_eop   = ~has_next;
        cmt_tmask = '0;
        cmt_data  = '0;
        for (int g = 0; g < NUM_PKTS; g++) begin
            if (PID_W'(g) == cur_pid) begin
                cmt_tmask = h_tmask[g*NUM_LANES +: NUM_LANES];
                cmt_data  = h_data[g*NUM_LANES*32 +: NUM_LANES*32];
            end
        end
    end

    // FIFO pointer/count and serializer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pid_d    = pid_q;
        sop_d    = sop_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (fire) begin
            if (cmt_eop) begin
                pid_d = '0;
                sop_d = 1'b1;
            end else begin
                pid_d = nxt_pid;
                sop_d = 1'b0;
            end
        end
    end

    // Storage next-state: write the incoming response at the tail
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {rsp_uuid_in, rsp_wid_in, rsp_tmask_in, rsp_PC_in, rsp_rd_in,
                               rsp_wb_in, rsp_data_in};
        end
    end

    // Control state with asynchronous reset; discards any in-flight response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pid_q    <= '0;
            sop_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pid_q    <= pid_d;
            sop_q    <= sop_d;
        end
    end

    // Payload storage needs no reset; it is only read while count is nonzero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef TEX_RSP_COMMIT_PERF_EN
    logic [31:0] perf_rsp_q, perf_rsp_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running wrap-around event counters
    always_comb begin
        perf_rsp_d   = perf_rsp_q + (push ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q + ((cmt_valid & ~cmt_ready) ? 32'd1 : 32'd0);
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_rsp_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rsp_q   <= perf_rsp_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_rsp_count   = perf_rsp_q;
    assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: doc/tex_rsp_commit.md
Name: tex_rsp_commit

Overview:
- Receiving (slave) end of the texture-unit response channel.
- Accepts full-warp texture responses (uuid, wid, tmask, PC, rd, wb, per-thread data), buffers them in a small FIFO, and serializes each one onto a narrower commit/writeback port of NUM_LANES lanes per beat.
- Lane groups with no active threads are skipped.
- Sits between the texture unit and the commit stage arbiter.

Parameters:
- NUM_THREADS, `NUM_THREADS, threads per warp; must be a multiple of NUM_LANES.
- NUM_LANES, 2, lanes per commit beat.
- DEPTH, 2, response FIFO entries (power of 2, >=2).
- NUM_PKTS, NUM_THREADS/NUM_LANES, derived; beats per full response.
- PID_W, max(1, clog2(NUM_PKTS)), derived; packet-index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rsp_valid_in  in  1  texture response valid
- rsp_uuid_in  in  `UUID_BITS  instruction uuid
- rsp_wid_in  in  `NW_BITS  warp id
- rsp_tmask_in  in  NUM_THREADS  thread mask
- rsp_PC_in  in  32  instruction PC
- rsp_rd_in  in  `NR_BITS  destination register
- rsp_wb_in  in  1  writeback enable
- rsp_data_in  in  NUM_THREADS*32  per-thread texel data, thread t at [32t+31:32t]
- rsp_ready_out  out  1  response accepted when valid&ready
- cmt_valid  out  1  commit beat valid
- cmt_uuid  out  `UUID_BITS  from head entry
- cmt_wid  out  `NW_BITS  from head entry
- cmt_PC  out  32  from head entry
- cmt_rd  out  `NR_BITS  from head entry
- cmt_wb  out  1  from head entry
- cmt_tmask  out  NUM_LANES  tmask bits of current lane group
- cmt_data  out  NUM_LANES*32  data of current lane group, raw (inactive lanes not zeroed)
- cmt_pid  out  PID_W  current lane-group index
- cmt_sop  out  1  first beat of response
- cmt_eop  out  1  last beat of response
- cmt_ready  in  1  commit stage accepts beat

Behaviour:
- Reset (reset==0, async): FIFO wr/rd pointers and count = 0, pid = 0, sop flag = 1; cmt_valid = 0, rsp_ready_out = 1 after release.
  - Other cmt_* outputs are don't-care while cmt_valid = 0.
  - Any in-flight response is discarded.
- Input:
  - rsp_ready_out = (count != DEPTH), derived from registered count only; no combinational path from rsp_valid_in.
  - Push on rsp_valid_in & rsp_ready_out.
- Latency: a response pushed in cycle N is earliest at cmt in cycle N+1 (no bypass).
- Output:
  - cmt_valid = (count != 0).
  - Group g = tmask bits [g*NUM_LANES +: NUM_LANES].
  - Beat fires on cmt_valid & cmt_ready. cmt_* hold stable while cmt_valid & !cmt_ready.
- Serializer state: pid register plus sop flag.
  - First beat of an entry: cmt_pid = lowest nonzero group, or 0 if tmask == 0.
  - next_pid = lowest nonzero group > current pid. cmt_eop = no such group exists.
  - On fire with !eop: pid <= next_pid, sop <= 0.
  - On fire with eop: pop entry, pid <= 0, sop <= 1.
- tmask == 0: exactly one beat, pid 0, cmt_tmask 0, sop = eop = 1.
- wb is passed through unchanged; wb = 0 entries are serialized identically.
- Push and pop in the same cycle: count unchanged; legal at any non-full count.
  - When full, no push (ready = 0), so the count stays consistent.
- Pointers wrap modulo DEPTH.
- Ordering is strict FIFO; beats of different responses never interleave.

Optional Feature:
- Macro TEX_RSP_COMMIT_PERF_EN.
- Defined: adds outputs perf_rsp_count (out, 32) and perf_stall_count (out, 32).
  - perf_rsp_count increments on each input push.
  - perf_stall_count increments each cycle cmt_valid & !cmt_ready.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- NUM_THREADS = 4, NUM_LANES = 2, DEPTH = 2 throughout.
- Full mask: push tmask=4'b1111, data {D3,D2,D1,D0}, cmt_ready=1.
  - Cycle N+1: pid=0, tmask=2'b11, data={D1,D0}, sop=1, eop=0.
  - Cycle N+2: pid=1, data={D3,D2}, sop=0, eop=1, entry popped.
- Skipped group: tmask=4'b1100 -> single beat pid=1, tmask=2'b11, sop=eop=1.
- Empty mask: tmask=4'b0000 -> single beat pid=0, tmask=2'b00, sop=eop=1.
- Backpressure: cmt_ready=0, offer 3 responses A, B, C.
  - A and B accepted; rsp_ready_out=0 and C held.
  - cmt outputs stable. Raise cmt_ready -> beats in order A, B, C; C accepted the cycle after A's eop pop.
- Reset mid-operation: reset=0 during the second beat of a 4'b1111 response -> cmt_valid=0 immediately (async). After release: rsp_ready_out=1, cmt_valid=0 until a new push.
- Perf (TEX_RSP_COMMIT_PERF_EN): 3 pushes with cmt_ready=0 for 5 cycles while valid -> perf_rsp_count=3, perf_stall_count=5.
